// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - operator/datapath signal bundle for the CPU sequencer
interface cpu_sequencer_if;
  logic       step;
  logic [3:0] sw;
  logic [1:0] op_sw;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       alu_z;
  logic [3:0] operand;
  logic       load_a;
  logic       load_b;
  logic [1:0] alu_op;
  logic       alu_enable;
  logic [3:0] result;
  logic       carry;
  logic       z;
  logic       done;
  logic       busy;
  logic [2:0] state_code;

  modport slave (
    input  step, sw, op_sw, alu_result, alu_carry, alu_z,
    output operand, load_a, load_b, alu_op, alu_enable,
           result, carry, z, done, busy, state_code
  );

  modport master (
    output step, sw, op_sw, alu_result, alu_carry, alu_z,
    input  operand, load_a, load_b, alu_op, alu_enable,
           result, carry, z, done, busy, state_code
  );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - push-button sequencer for the 4-bit two-register CPU datapath
module cpu_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ALU_LATENCY     = 2
) (
  input logic             clock,
  input logic             reset,
  cpu_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_LATCH   = 3'd4,
    S_SHOW    = 3'd5
  } state_t;

  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  LAT     = 4'(ALU_LATENCY);

  logic        r_sync1;
  logic        r_sync2;
  logic [19:0] r_db_cnt;
  logic        r_db_level;
  logic        r_db_prev;
  logic        w_step_pulse;

  state_t      r_state;
  logic [3:0]  r_alu_cnt;
  logic [3:0]  r_operand;
  logic        r_load_a;
  logic        r_load_b;
  logic [1:0]  r_alu_op;
  logic        r_alu_enable;
  logic [3:0]  r_result;
  logic        r_carry;
  logic        r_z;
  logic        r_done;
  logic        r_busy;

  // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
    end else begin
      r_sync1   <= bus.step;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db_level;
      if (r_sync2 != r_db_level) begin
        if (r_db_cnt == DB_LAST) begin
          r_db_level <= r_sync2;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 20'd1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_step_pulse = r_db_level & ~r_db_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_WAIT_A;
      r_alu_cnt    <= '0;
      r_operand    <= '0;
      r_load_a     <= 1'b0;
      r_load_b     <= 1'b0;
      r_alu_op     <= '0;
      r_alu_enable <= 1'b0;
      r_result     <= '0;
      r_carry      <= 1'b0;
      r_z          <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_load_a <= 1'b0;
      r_load_b <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_WAIT_A: if (w_step_pulse) begin
          r_operand <= bus.sw;
          r_load_a  <= 1'b1;
          r_state   <= S_WAIT_B;
        end
        S_WAIT_B: if (w_step_pulse) begin
          r_operand <= bus.sw;
          r_load_b  <= 1'b1;
          r_state   <= S_WAIT_OP;
        end
        S_WAIT_OP: if (w_step_pulse) begin
          r_alu_op     <= bus.op_sw;
          r_alu_enable <= 1'b1;
          r_alu_cnt    <= 4'd1;
          r_busy       <= 1'b1;
          r_state      <= S_EXEC;
        end
        // Counter starts at 1 on entry, so enable spans exactly ALU_LATENCY cycles.
        S_EXEC: begin
          if (r_alu_cnt == LAT) begin
            r_alu_enable <= 1'b0;
            r_state      <= S_LATCH;
          end else begin
            r_alu_cnt <= r_alu_cnt + 4'd1;
          end
        end
        S_LATCH: begin
          r_result <= bus.alu_result;
          r_carry  <= bus.alu_carry;
          r_z      <= bus.alu_z;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_SHOW;
        end
        S_SHOW: if (w_step_pulse) begin
          r_state <= S_WAIT_A;
        end
        default: begin
          r_alu_enable <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_WAIT_A;
        end
      endcase
    end
  end

  assign bus.operand    = r_operand;
  assign bus.load_a     = r_load_a;
  assign bus.load_b     = r_load_b;
  assign bus.alu_op     = r_alu_op;
  assign bus.alu_enable = r_alu_enable;
  assign bus.result     = r_result;
  assign bus.carry      = r_carry;
  assign bus.z          = r_z;
  assign bus.done       = r_done;
  assign bus.busy       = r_busy;
  assign bus.state_code = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst2 = 1'b1;
  logic       step = 1'b0;
  logic [3:0] sw = 4'h0;
  logic [1:0] op_sw = 2'b00;
  logic [3:0] alu_r = 4'h0;
  logic       alu_c = 1'b0;
  logic       alu_z = 1'b0;

  always #5 clk = ~clk;

  cpu_sequencer_if bus1();
  cpu_sequencer_if bus2();

  assign bus1.step = step;
  assign bus1.sw = sw;
  assign bus1.op_sw = op_sw;
  assign bus1.alu_result = alu_r;
  assign bus1.alu_carry = alu_c;
  assign bus1.alu_z = alu_z;
  assign bus2.step = step;
  assign bus2.sw = sw;
  assign bus2.op_sw = op_sw;
  assign bus2.alu_result = alu_r;
  assign bus2.alu_carry = alu_c;
  assign bus2.alu_z = alu_z;

  cpu_sequencer #(.DEBOUNCE_CYCLES(4), .ALU_LATENCY(2)) u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus1.slave)
  );

  // Long-latency instance with a short debounce, so a second press can land inside EXEC.
  cpu_sequencer #(.DEBOUNCE_CYCLES(1), .ALU_LATENCY(8)) u_dut_long (
    .clock (clk),
    .reset (rst2),
    .bus   (bus2.slave)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] r;
    logic       c;
    logic       z;
  } vec_t;

  typedef struct {
    int         kind;
    logic [3:0] val;
    logic       c;
    logic       z;
    logic [1:0] op;
  } sb_t;

  sb_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  en_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [3:0] val, input logic c, input logic z,
                      input logic [1:0] op);
    sb_t e;
    e.kind = kind;
    e.val = val;
    e.c = c;
    e.z = z;
    e.op = op;
    q.push_back(e);
  endtask

  task automatic press();
    @(posedge clk);
    #2 step = 1'b1;
    repeat (12) @(posedge clk);
    #2 step = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_state(input int which, input int code, input int bound, output bit ok);
    ok = 1'b0;
    for (int j = 0; j < bound; j++) begin
      @(negedge clk);
      if (int'(which == 1 ? bus1.state_code : bus2.state_code) == code) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_operand"}, int'(bus1.operand), 0);
    chk({tag, "_load_a"}, int'(bus1.load_a), 0);
    chk({tag, "_load_b"}, int'(bus1.load_b), 0);
    chk({tag, "_alu_op"}, int'(bus1.alu_op), 0);
    chk({tag, "_alu_enable"}, int'(bus1.alu_enable), 0);
    chk({tag, "_result"}, int'(bus1.result), 0);
    chk({tag, "_carry"}, int'(bus1.carry), 0);
    chk({tag, "_z"}, int'(bus1.z), 0);
    chk({tag, "_done"}, int'(bus1.done), 0);
    chk({tag, "_busy"}, int'(bus1.busy), 0);
    chk({tag, "_state"}, int'(bus1.state_code), 0);
  endtask

  task automatic monitor();
    sb_t e;
    int  kind;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_cnt = 0;
      end else begin
        chk("busy_vs_state", int'(bus1.busy),
            int'(bus1.state_code == 3'd3 || bus1.state_code == 3'd4));
        chk("enable_outside_exec", int'(bus1.alu_enable && bus1.state_code != 3'd3), 0);
        chk("load_overlap", int'(bus1.load_a && bus1.load_b), 0);
        if (bus1.load_a || bus1.load_b || bus1.done) begin
          kind = bus1.load_a ? 0 : (bus1.load_b ? 1 : 2);
          if (q.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
          end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind < 2) begin
              chk(kind == 0 ? "operand_at_load_a" : "operand_at_load_b",
                  int'(bus1.operand), int'(e.val));
            end else begin
              chk("result_at_done", int'(bus1.result), int'(e.val));
              chk("carry_at_done", int'(bus1.carry), int'(e.c));
              chk("z_at_done", int'(bus1.z), int'(e.z));
              chk("alu_op_at_done", int'(bus1.alu_op), int'(e.op));
              chk("state_at_done", int'(bus1.state_code), 5);
              chk("enable_cycles", en_cnt, 2);
              en_cnt = 0;
            end
          end
        end
        if (bus1.alu_enable) en_cnt++;
      end
    end
  endtask

  task automatic run_tests();
    vec_t tbl[4];
    bit   ok;
    int   n_en;
    int   n_done;
    int   bad_state;
    bit   got_done;

    tbl[0] = '{a: 4'h3, b: 4'h5, op: 2'd0, r: 4'h8, c: 1'b0, z: 1'b0};
    tbl[1] = '{a: 4'hF, b: 4'h1, op: 2'd1, r: 4'h0, c: 1'b1, z: 1'b1};
    tbl[2] = '{a: 4'hA, b: 4'h6, op: 2'd2, r: 4'hC, c: 1'b0, z: 1'b0};
    tbl[3] = '{a: 4'h0, b: 4'h0, op: 2'd3, r: 4'h7, c: 1'b1, z: 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      alu_r = ~tbl[i].r;
      alu_c = ~tbl[i].c;
      alu_z = ~tbl[i].z;
      sw = tbl[i].a;
      push(0, tbl[i].a, 1'b0, 1'b0, 2'd0);
      press();
      chk("state_after_a", int'(bus1.state_code), 1);
      if (i > 0) begin
        chk("result_hold_a", int'(bus1.result), int'(tbl[i-1].r));
        chk("carry_hold_a", int'(bus1.carry), int'(tbl[i-1].c));
        chk("z_hold_a", int'(bus1.z), int'(tbl[i-1].z));
        chk("alu_op_hold_a", int'(bus1.alu_op), int'(tbl[i-1].op));
      end
      sw = ~tbl[i].a;
      repeat (5) @(negedge clk);
      chk("operand_hold", int'(bus1.operand), int'(tbl[i].a));
      sw = tbl[i].b;
      push(1, tbl[i].b, 1'b0, 1'b0, 2'd0);
      press();
      chk("state_after_b", int'(bus1.state_code), 2);
      if (i > 0) chk("result_hold_b", int'(bus1.result), int'(tbl[i-1].r));
      alu_r = tbl[i].r;
      alu_c = tbl[i].c;
      alu_z = tbl[i].z;
      op_sw = tbl[i].op;
      push(2, tbl[i].r, tbl[i].c, tbl[i].z, tbl[i].op);
      press();
      op_sw = ~tbl[i].op;
      chk("state_show", int'(bus1.state_code), 5);
      press();
      chk("show_to_wait_a", int'(bus1.state_code), 0);
      chk("alu_op_kept", int'(bus1.alu_op), int'(tbl[i].op));
    end

    sw = 4'h2;
    push(0, 4'h2, 1'b0, 1'b0, 2'd0);
    press();
    sw = 4'h4;
    push(1, 4'h4, 1'b0, 1'b0, 2'd0);
    press();
    op_sw = 2'd1;
    @(posedge clk);
    #2 step = 1'b1;
    wait_state(1, 3, 40, ok);
    chk("reached_exec", int'(ok), 1);
    rst = 1'b1;
    step = 1'b0;
    #1;
    chk_zero("mid_exec_reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    sw = 4'h9;
    push(0, 4'h9, 1'b0, 1'b0, 2'd0);
    press();
    chk("after_reset_state", int'(bus1.state_code), 1);

    sw = 4'h6;
    push(1, 4'h6, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #2 step = 1'b1;
    repeat (1000) @(posedge clk);
    #2 step = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("held_button_state", int'(bus1.state_code), 2);
    alu_r = 4'h1;
    alu_c = 1'b0;
    alu_z = 1'b0;
    op_sw = 2'd3;
    push(2, 4'h1, 1'b0, 1'b0, 2'd3);
    press();
    chk("held_seq_show", int'(bus1.state_code), 5);
    press();
    chk("held_seq_wait_a", int'(bus1.state_code), 0);

    sw = 4'h7;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #2 step = (k % 2 == 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("bounce_no_step", int'(bus1.state_code), 0);
    push(0, 4'h7, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #2 step = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bounce_accepted", int'(bus1.state_code), 1);
    step = 1'b0;
    repeat (15) @(negedge clk);
    chk("bounce_final_state", int'(bus1.state_code), 1);

    rst = 1'b1;
    @(posedge clk);
    #2 rst2 = 1'b0;
    press();
    press();
    chk("long_state_wait_op", int'(bus2.state_code), 2);
    @(posedge clk);
    #2 step = 1'b1;
    wait_state(2, 3, 40, ok);
    chk("long_reached_exec", int'(ok), 1);
    step = 1'b0;
    @(posedge clk);
    #2 step = 1'b1;
    n_en = 1;
    got_done = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (bus2.done) begin
        got_done = 1'b1;
        chk("long_state_at_done", int'(bus2.state_code), 5);
        break;
      end
      if (bus2.alu_enable) n_en++;
    end
    chk("long_done_seen", int'(got_done), 1);
    chk("long_enable_cycles", n_en, 8);
    n_done = 0;
    bad_state = 0;
    for (int j = 0; j < 40; j++) begin
      if (j == 20) step = 1'b0;
      @(negedge clk);
      if (bus2.done) n_done++;
      if (bus2.state_code != 3'd5) bad_state++;
    end
    chk("long_extra_done", n_done, 0);
    chk("long_left_show", bad_state, 0);
    chk("long_final_state", int'(bus2.state_code), 5);
  endtask

  initial begin
    fork
      monitor();
      run_tests();
      begin
        repeat (60000) @(posedge clk);
        chk("watchdog_expired", 1, 0);
      end
    join_any
    disable fork;
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Operator-driven controller that sequences the 4-bit two-register CPU datapath from one push button.
Steps: load operand A from the switches, load operand B, select the ALU operation, fire the ALU for a fixed number of cycles, then latch and hold the result and flags.
Sits between the board switches/button and the register-load, ALU-enable and display inputs.
Exports a 3-bit state code for the 7-segment display.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable clock cycles required before a button level change is accepted (5 ms at 50 MHz); legal range 1..2^20-1; bench uses 4.
ALU_LATENCY, 2, cycles alu_enable is held high before the result is sampled; legal range 1..15.

Ports:
clock  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
step  in  1  raw push button, active-high, asynchronous to clock, bouncy
sw  in  4  operand switches
op_sw  in  2  operation-select switches
alu_result  in  4  ALU result
alu_carry  in  1  ALU carry flag
alu_z  in  1  ALU zero flag
operand  out  4  data presented to both operand registers
load_a  out  1  one-cycle load strobe, register A
load_b  out  1  one-cycle load strobe, register B
alu_op  out  2  latched operation code to the ALU
alu_enable  out  1  ALU enable
result  out  4  latched result
carry  out  1  latched carry
z  out  1  latched zero flag
done  out  1  one-cycle pulse when result/flags update
busy  out  1  high in EXEC and LATCH
state_code  out  3  current state encoding, for the display

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; state WAIT_A.
  - Synchroniser flops, debounce counter, debounced level and ALU cycle counter cleared.
  - Reset mid-EXEC aborts with no done pulse and no result update.
- Input conditioning:
  - step passes through a 2-flop synchroniser.
  - The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the counter.
  - step_pulse is one cycle high on the debounced rising edge. Falling edges produce nothing.
  - Holding the button yields exactly one step_pulse.
- Registered outputs. If step_pulse is high in cycle n, the resulting output change is visible in cycle n+1.
- State encodings: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, LATCH=4, SHOW=5. Encodings 6 and 7 are unreachable and recover to WAIT_A on the next clock.
- WAIT_A: on step_pulse → operand<=sw, load_a=1 for one cycle, go WAIT_B.
- WAIT_B: on step_pulse → operand<=sw, load_b=1 for one cycle, go WAIT_OP.
- WAIT_OP: on step_pulse → alu_op<=op_sw, go EXEC.
- EXEC:
  - alu_enable=1 for exactly ALU_LATENCY consecutive cycles, counted by a 4-bit counter.
  - Then go LATCH; alu_enable=0 from the cycle LATCH is entered.
- LATCH:
  - Single cycle. Samples alu_result/alu_carry/alu_z into result/carry/z and pulses done.
  - The new values are visible on the following cycle, together with done.
  - Go SHOW.
- SHOW: result/carry/z held. On step_pulse → go WAIT_A.
- Value retention:
  - result, carry and z keep their values through the next WAIT_A..EXEC sequence and change only in LATCH.
  - operand holds its last loaded value between strobes.
  - alu_op holds until the next WAIT_OP step.
- Ignored inputs:
  - step_pulse in EXEC or LATCH is discarded, not queued.
  - Changes on sw/op_sw outside the accepting step have no effect.
  - load_a and load_b are never high in the same cycle.
  - alu_enable is never high outside EXEC.
- busy=1 exactly while state is EXEC or LATCH.

Test Plan:
- Reset mid-sequence: assert reset while in EXEC → all outputs 0 immediately, state_code=0; after release, a clean press loads A normally.
- Full sequence (DEBOUNCE_CYCLES=4, ALU_LATENCY=2): press with sw=4'h3, press with sw=4'h5, press with op_sw=2'b00; model ALU returns 4'h8/c=0/z=0.
  - Required: load_a one cycle with operand=3; load_b one cycle with operand=5; alu_op=0; alu_enable high exactly 2 cycles.
  - Then result=8 and done=1 in the same cycle; state_code=5.
- Bounce rejection: step toggles every 2 cycles for 20 cycles, then is held high for 10 → exactly one load_a pulse; state_code 0→1 only.
- Ignored press: press during EXEC with ALU_LATENCY=8 → no extra transition; after done the state is SHOW (5), not WAIT_A.
- Flag latch and hold: ALU returns 4'h0/c=1/z=1 → carry=1, z=1.
  - Next press to WAIT_A, then change sw and the ALU outputs → result/carry/z unchanged until the next LATCH.
- Held button: hold step high for 1000 cycles in WAIT_B → one load_b pulse; state stays WAIT_OP.
